// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement add/subtract with valid/ready handshake.
// Processes a WIDTH-bit operand pair CHUNK bits per clock (WIDTH/CHUNK RUN cycles).
// Optional feature: define ADDSUB_SAT_EN to clamp the result on signed overflow.
module addsub_serial #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N  = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (CHUNK < 1 || WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_err
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // holds y already inverted for subtraction
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] raw_nxt;
  logic [WIDTH-1:0] fin_sum;
  logic             c_msb_in;
  logic             c_out;
  logic             ovf_nxt;

  // Per-cycle CHUNK-bit adder on the current slice, plus final flag/result derivation.
  always_comb begin
    slice_sum = {1'b0, a_q[int'(cnt_q) * int'(CHUNK) +: CHUNK]}
              + {1'b0, b_q[int'(cnt_q) * int'(CHUNK) +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    raw_nxt = sum_q;
    raw_nxt[int'(cnt_q) * int'(CHUNK) +: CHUNK] = slice_sum[CHUNK-1:0];
    c_out = slice_sum[CHUNK];
    // Carry into the MSB recovered from the MSB's own full-adder inputs and output.
    c_msb_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ raw_nxt[WIDTH-1];
    ovf_nxt  = c_msb_in ^ c_out;
    fin_sum  = raw_nxt;
`ifdef ADDSUB_SAT_EN
    if (ovf_nxt) begin
      fin_sum = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Next-state logic for the IDLE -> RUN -> DONE handshake sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = x;
          b_d     = y ^ {WIDTH{sel}};
          carry_d = sel;  // +1 completes the two's-complement negate
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = raw_nxt;
        carry_d = c_out;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = fin_sum;
          cout_d  = c_out;
          ovf_d   = ovf_nxt;
          zero_d  = (fin_sum == '0);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed checks on a WIDTH=6/CHUNK=2 instance plus a WIDTH=8
// sweep over CHUNK in {1,2,4,8} against an integer-arithmetic reference model.
module tb_addsub_serial;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] x;
  logic [5:0] y;
  logic       sel;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] sum;
  logic       cout;
  logic       overflow;
  logic       zero;

  logic       sw_iv[4];
  logic       sw_ir[4];
  logic [7:0] sw_x[4];
  logic [7:0] sw_y[4];
  logic       sw_sel[4];
  logic       sw_ov[4];
  logic       sw_or[4];
  logic [7:0] sw_s[4];
  logic       sw_co[4];
  logic       sw_of[4];
  logic       sw_z[4];

  int n_total;
  int n_bad;

`ifdef ADDSUB_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  addsub_serial #(.WIDTH(6), .CHUNK(2)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    addsub_serial #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (sw_iv[g]),
      .in_ready  (sw_ir[g]),
      .x         (sw_x[g]),
      .y         (sw_y[g]),
      .sel       (sw_sel[g]),
      .out_valid (sw_ov[g]),
      .out_ready (sw_or[g]),
      .sum       (sw_s[g]),
      .cout      (sw_co[g]),
      .overflow  (sw_of[g]),
      .zero      (sw_z[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Returns {sum, cout, overflow, zero} for an 8-bit operation.
  function automatic logic [10:0] model8(input logic [7:0] ax, input logic [7:0] ay,
                                         input logic as);
    int sx;
    int sy;
    int r;
    logic ovf;
    logic co;
    logic [7:0] sm;
    sx  = $signed(ax);
    sy  = $signed(ay);
    r   = as ? sx - sy : sx + sy;
    ovf = (r > 127) || (r < -128);
    co  = as ? (ax >= ay) : ((int'(ax) + int'(ay)) > 255);
    sm  = r[7:0];
    if (SatEn && ovf) sm = ax[7] ? 8'h80 : 8'h7f;
    return {sm, co, ovf, (sm == 8'h00)};
  endfunction

  // Issue one op on the 6-bit DUT and wait (bounded) for out_valid; lat = edges after accept.
  task automatic run_op(input logic [5:0] ax, input logic [5:0] ay, input logic as,
                        output int lat);
    @(negedge clk);
    x = ax; y = ay; sel = as; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_op(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "/ov_low"}, 32'(out_valid), 32'd0);
    check_eq({tag, "/ir_high"}, 32'(in_ready), 32'd1);
  endtask

  task automatic sw_op(input int g, input logic [7:0] ax, input logic [7:0] ay, input logic as);
    logic [10:0] e;
    int lat;
    e = model8(ax, ay, as);
    @(negedge clk);
    sw_x[g] = ax; sw_y[g] = ay; sw_sel[g] = as; sw_iv[g] = 1'b1;
    @(posedge clk); #1;
    sw_iv[g] = 1'b0;
    lat = 0;
    while (!sw_ov[g] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq($sformatf("sw%0d_lat", g), 32'(lat), 32'(8 >> g));
    check_eq($sformatf("sw%0d_res x=%0h y=%0h s=%0d", g, ax, ay, as),
             32'({sw_s[g], sw_co[g], sw_of[g], sw_z[g]}), 32'(e));
    @(negedge clk);
    sw_or[g] = 1'b1;
    @(posedge clk); #1;
    sw_or[g] = 1'b0;
    check_eq($sformatf("sw%0d_done", g), 32'({sw_ov[g], sw_ir[g]}), 32'b01);
  endtask

  typedef struct {
    logic [5:0] vx;
    logic [5:0] vy;
    logic       vs;
    logic [5:0] s_wrap;
    logic [5:0] s_sat;
    logic       c;
    logic       o;
    logic       z;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    logic [7:0] rx;
    logic [7:0] ry;
    logic [5:0] exp_s;

    n_total = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sw_iv[i] = 1'b0; sw_or[i] = 1'b0; sw_x[i] = '0; sw_y[i] = '0; sw_sel[i] = 1'b0;
    end

    //            x      y      sel   wrap   sat    c     o     z
    vecs[0] = '{6'd5,  6'd3,  1'b0, 6'd8,  6'd8,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{6'd31, 6'd1,  1'b0, 6'd32, 6'd31, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{6'd5,  6'd3,  1'b1, 6'd2,  6'd2,  1'b1, 1'b0, 1'b0};
    vecs[3] = '{6'd32, 6'd1,  1'b1, 6'd31, 6'd32, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{6'd0,  6'd32, 1'b1, 6'd32, 6'd31, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{6'd63, 6'd63, 1'b0, 6'd62, 6'd62, 1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst/ir", 32'(in_ready), 32'd1);
    check_eq("rst/ov", 32'(out_valid), 32'd0);
    check_eq("rst/res", 32'({sum, cout, overflow, zero}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      exp_s = SatEn ? vecs[i].s_sat : vecs[i].s_wrap;
      run_op(vecs[i].vx, vecs[i].vy, vecs[i].vs, lat);
      check_eq($sformatf("v%0d/lat", i), 32'(lat), 32'd3);
      check_eq($sformatf("v%0d/sum", i), 32'(sum), 32'(exp_s));
      check_eq($sformatf("v%0d/flags", i), 32'({cout, overflow, zero}),
               32'({vecs[i].c, vecs[i].o, vecs[i].z}));
      check_eq($sformatf("v%0d/ir", i), 32'(in_ready), 32'd0);
      release_op($sformatf("v%0d", i));
    end

    // Zero result held under back-pressure, with a stray in_valid pulse.
    run_op(6'd7, 6'd7, 1'b1, lat);
    check_eq("bp/lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      x = 6'd1; y = 6'd2; sel = 1'b0;
      @(posedge clk); #1;
      check_eq($sformatf("bp%0d/hs", i), 32'({out_valid, in_ready}), 32'b10);
      check_eq($sformatf("bp%0d/res", i), 32'({sum, cout, overflow, zero}),
               32'({6'd0, 1'b1, 1'b0, 1'b1}));
    end
    in_valid = 1'b0;
    release_op("bp");
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp/noqueue", 32'({out_valid, in_ready}), 32'b01);

    // Reset asserted during the second RUN cycle.
    @(negedge clk);
    x = 6'd21; y = 6'd21; sel = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mrst/hs", 32'({out_valid, in_ready}), 32'b01);
    check_eq("mrst/res", 32'({sum, cout, overflow, zero}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(6'd1, 6'd1, 1'b0, lat);
    check_eq("mrst/lat", 32'(lat), 32'd3);
    check_eq("mrst/sum", 32'({sum, cout, overflow, zero}), 32'({6'd2, 3'b000}));
    release_op("mrst");

    // WIDTH=8 sweep; every tenth op uses the most negative x to stress overflow.
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 1000; k++) begin
        rx = (k % 10 == 0) ? 8'h80 : 8'($urandom);
        ry = (k % 7 == 0) ? 8'h80 : 8'($urandom);
        sw_op(g, rx, ry, 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
